// File: rtl/prog_loader_pkg.sv
// Shared types and stream-format constants for the boot-time program loader.
// Optional build macro: CHECKSUM_EN adds the trailing checksum field and CSUM state.
package prog_loader_pkg;

   localparam int unsigned HDR_BYTES  = 4;
   localparam int unsigned WORD_BYTES = 4;

   typedef enum logic [2:0] {
      ST_HDR,
      ST_DATA,
      ST_WR,
`ifdef CHECKSUM_EN
      ST_CSUM,
`endif
      ST_DONE,
      ST_ERROR
   } loader_state_t;

   // Byte address of word idx; wraps modulo 2^32.
   function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [31:0] idx);
      return base + idx * 32'(WORD_BYTES);
   endfunction

endpackage

// File: rtl/prog_loader_if.sv
// Byte-stream valid/ready handshake between the image source and the loader.
interface prog_loader_if;

   logic       in_valid;
   logic [7:0] in_data;
   logic       in_ready;

   modport master (output in_valid, output in_data, input  in_ready);
   modport slave  (input  in_valid, input  in_data, output in_ready);

endinterface

// File: rtl/prog_loader_byte_assembler.sv
// Collects four stream bytes into a little-endian 32-bit word (first byte -> bits [7:0]).
module byte_assembler
   import prog_loader_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        clear,
   input  logic        byte_en,
   input  logic [7:0]  byte_in,
   output logic [31:0] word,
   output logic        word_valid
);

   localparam logic [1:0] LAST = 2'(WORD_BYTES - 1);

   logic [1:0]  cnt;
   // Only the three earlier bytes need storage; the fourth is taken straight from byte_in.
   logic [23:0] shreg;

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         cnt   <= '0;
         shreg <= '0;
      end else if (byte_en) begin
         cnt   <= cnt + 2'd1;
         shreg <= {byte_in, shreg[23:8]};
      end
   end

   assign word       = {byte_in, shreg};
   assign word_valid = byte_en && (cnt == LAST);

endmodule

// File: rtl/prog_loader.sv
// Boot loader: streams a counted LE word image into memory and holds the core until done.
// Optional build macro: CHECKSUM_EN verifies a trailing 32-bit sum of the data words.
module prog_loader
   import prog_loader_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter int unsigned MAX_WORDS = 256,
   parameter int unsigned CNT_W     = 16
) (
   input  logic              clk,
   input  logic              reset,
   prog_loader_if.slave      stream,
   input  logic              reload,
   output logic              mem_we,
   output logic [31:0]       mem_addr,
   output logic [31:0]       mem_wdata,
   output logic              core_hold,
   output logic              done,
   output logic              err
);

   loader_state_t    state;
   logic             ready_q;
   logic [CNT_W-1:0] wcnt;
   logic [CNT_W-1:0] n_words;
   logic             byte_en;
   logic             asm_clear;
   logic [31:0]      word;
   logic             word_valid;
`ifdef CHECKSUM_EN
   logic [31:0]      sum_q;
`endif

   assign stream.in_ready = ready_q;
   assign byte_en         = stream.in_valid && ready_q;
   assign asm_clear       = reload && (state == ST_DONE || state == ST_ERROR);

   byte_assembler u_asm (
      .clk        (clk),
      .reset      (reset),
      .clear      (asm_clear),
      .byte_en    (byte_en),
      .byte_in    (stream.in_data),
      .word       (word),
      .word_valid (word_valid)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= ST_HDR;
         ready_q   <= 1'b1;
         mem_we    <= 1'b0;
         mem_addr  <= BASE_ADDR;
         mem_wdata <= '0;
         core_hold <= 1'b1;
         done      <= 1'b0;
         err       <= 1'b0;
         wcnt      <= '0;
         n_words   <= '0;
`ifdef CHECKSUM_EN
         sum_q     <= '0;
`endif
      end else begin
         mem_we <= 1'b0;
         case (state)
            ST_HDR: begin
               if (word_valid) begin
                  if (word > MAX_WORDS) begin
                     state   <= ST_ERROR;
                     ready_q <= 1'b0;
                     err     <= 1'b1;
                  end else if (word == '0) begin
`ifdef CHECKSUM_EN
                     state     <= ST_CSUM;
`else
                     state     <= ST_DONE;
                     ready_q   <= 1'b0;
                     core_hold <= 1'b0;
                     done      <= 1'b1;
`endif
                  end else begin
                     n_words <= CNT_W'(word);
                     state   <= ST_DATA;
                  end
               end
            end
            ST_DATA: begin
               if (word_valid) begin
                  state     <= ST_WR;
                  ready_q   <= 1'b0;
                  mem_we    <= 1'b1;
                  mem_addr  <= word_addr(BASE_ADDR, 32'(wcnt));
                  mem_wdata <= word;
`ifdef CHECKSUM_EN
                  sum_q     <= sum_q + word;
`endif
               end
            end
            ST_WR: begin
               wcnt <= wcnt + CNT_W'(1);
               if ((wcnt + CNT_W'(1)) == n_words) begin
`ifdef CHECKSUM_EN
                  state     <= ST_CSUM;
                  ready_q   <= 1'b1;
`else
                  state     <= ST_DONE;
                  core_hold <= 1'b0;
                  done      <= 1'b1;
`endif
               end else begin
                  state   <= ST_DATA;
                  ready_q <= 1'b1;
               end
            end
`ifdef CHECKSUM_EN
            ST_CSUM: begin
               if (word_valid) begin
                  ready_q <= 1'b0;
                  if (word == sum_q) begin
                     state     <= ST_DONE;
                     core_hold <= 1'b0;
                     done      <= 1'b1;
                  end else begin
                     state <= ST_ERROR;
                     err   <= 1'b1;
                  end
               end
            end
`endif
            ST_DONE, ST_ERROR: begin
               if (reload) begin
                  state     <= ST_HDR;
                  ready_q   <= 1'b1;
                  mem_addr  <= BASE_ADDR;
                  core_hold <= 1'b1;
                  done      <= 1'b0;
                  err       <= 1'b0;
                  wcnt      <= '0;
                  n_words   <= '0;
`ifdef CHECKSUM_EN
                  sum_q     <= '0;
`endif
               end
            end
            default: begin
               state   <= ST_ERROR;
               ready_q <= 1'b0;
               err     <= 1'b1;
            end
         endcase
      end
   end

endmodule
